// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: arbiter state encoding and priority-mode constants shared with the bus matrix.
package ahb_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, LOCK} arb_state_e;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: first asserted request searching upward from start+1 with wrap.
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [W-1:0] k;
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        k      = '0;
        // Scan farthest-first so the nearest requester after start overwrites.
        for (int i = N; i >= 1; i--) begin
            k = W'((int'(start) + i) % N);
            if (req[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
                idx       = k;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave-port master arbiter with burst/lock hold and data-phase tracking.
module ahb_slave_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int MAS_NUM   = 4,
    parameter int MAS_W     = $clog2(MAS_NUM),
    parameter int PRIO_MODE = 0
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [MAS_NUM-1:0] hreq,
    input  logic [MAS_NUM-1:0] hseq,
    input  logic [MAS_NUM-1:0] hlock,
    input  logic               hready,
    output logic [MAS_NUM-1:0] hgrant,
    output logic [MAS_W-1:0]   hmaster,
    output logic [MAS_W-1:0]   hmaster_dp,
    output logic               hsel_dp,
    output logic               hlocked
);
    localparam logic [MAS_W-1:0] LAST = MAS_W'(MAS_NUM - 1);

    arb_state_e         state, state_n;
    logic [MAS_W-1:0]   rr_ptr, rr_n, master_n, start, win_idx;
    logic [MAS_NUM-1:0] win_oh, grant_n;
    logic               win_valid, hold;

    assign start   = (PRIO_MODE == PRIO_FIXED) ? LAST : rr_ptr;
    assign hold    = (state != IDLE) & (hlock[hmaster] | (hseq[hmaster] & hreq[hmaster]));
    assign hlocked = (state == LOCK);

    ahb_rr_picker #(.N(MAS_NUM), .W(MAS_W)) u_pick (
        .req    (hreq),
        .start  (start),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    always_comb begin
        state_n  = IDLE;
        master_n = hmaster;
        rr_n     = rr_ptr;
        grant_n  = '0;
        if (hold) begin
            state_n = hlock[hmaster] ? LOCK : OWN;
            grant_n = hgrant;
        end else if (win_valid) begin
            state_n  = hlock[win_idx] ? LOCK : OWN;
            master_n = win_idx;
            rr_n     = win_idx;
            grant_n  = win_oh;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= IDLE;
            rr_ptr     <= LAST;
            hgrant     <= '0;
            hmaster    <= '0;
            hmaster_dp <= '0;
            hsel_dp    <= 1'b0;
        end else if (hready) begin
            state      <= state_n;
            rr_ptr     <= rr_n;
            hgrant     <= grant_n;
            hmaster    <= master_n;
            hmaster_dp <= hmaster;
            hsel_dp    <= (state != IDLE) & hreq[hmaster];
        end
    end
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter: directed vectors for round-robin and fixed-priority arbiter instances.
module tb_ahb_slave_arbiter;
    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] hreq = '0, hseq = '0, hlock = '0;
    logic       hready = 1'b1;
    logic [3:0] hgrant, fp_hgrant;
    logic [1:0] hmaster, hmaster_dp, fp_hmaster, fp_hmaster_dp;
    logic       hsel_dp, hlocked, fp_hsel_dp, fp_hlocked;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(.MAS_NUM(4), .PRIO_MODE(0)) dut (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hseq(hseq), .hlock(hlock), .hready(hready),
        .hgrant(hgrant), .hmaster(hmaster), .hmaster_dp(hmaster_dp), .hsel_dp(hsel_dp), .hlocked(hlocked)
    );

    ahb_slave_arbiter #(.MAS_NUM(4), .PRIO_MODE(1)) dut_fp (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hseq(hseq), .hlock(hlock), .hready(hready),
        .hgrant(fp_hgrant), .hmaster(fp_hmaster), .hmaster_dp(fp_hmaster_dp), .hsel_dp(fp_hsel_dp),
        .hlocked(fp_hlocked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_g [5];
        logic [1:0] rr_dp [5];
        rr_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        tick;
        tick;
        hreset = 1'b0;
        check("rst_grant", hgrant, 0);
        check("rst_master", hmaster, 0);
        check("rst_dp", hmaster_dp, 0);
        check("rst_sel", hsel_dp, 0);
        check("rst_lock", hlocked, 0);

        hreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("rr_grant%0d", i), hgrant, rr_g[i]);
            check($sformatf("rr_dp%0d", i), hmaster_dp, rr_dp[i]);
        end
        check("rr_sel", hsel_dp, 1);

        hreq = 4'b0110;
        tick;
        check("burst_b1", hgrant, 4'b0010);
        hseq = 4'b0010;
        tick;
        check("burst_b2", hgrant, 4'b0010);
        hready = 1'b0;
        hseq = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("wait_grant%0d", i), hgrant, 4'b0010);
            check($sformatf("wait_master%0d", i), hmaster, 1);
            check($sformatf("wait_dp%0d", i), hmaster_dp, 1);
            check($sformatf("wait_sel%0d", i), hsel_dp, 1);
        end
        hready = 1'b1;
        hseq = 4'b0010;
        tick;
        check("burst_b3", hgrant, 4'b0010);
        tick;
        check("burst_b4", hgrant, 4'b0010);
        hseq = 4'b0000;
        tick;
        check("handover", hgrant, 4'b0100);
        check("handover_dp", hmaster_dp, 1);

        hreq = 4'b1001;
        hlock = 4'b1000;
        tick;
        check("lock_grant", hgrant, 4'b1000);
        check("lock_flag", hlocked, 1);
        hreq = 4'b0001;
        tick;
        check("lock_idle_grant", hgrant, 4'b1000);
        check("lock_idle_sel", hsel_dp, 0);
        hreq = 4'b1001;
        tick;
        check("lock_again", hgrant, 4'b1000);
        check("lock_again_sel", hsel_dp, 1);
        hlock = 4'b0000;
        hreq = 4'b0001;
        tick;
        check("unlock_grant", hgrant, 4'b0001);
        check("unlock_flag", hlocked, 0);

        hreq = 4'b1010;
        tick;
        check("fp_a", fp_hgrant, 4'b0010);
        check("rr_a", hmaster, 1);
        tick;
        check("fp_b", fp_hgrant, 4'b0010);
        check("rr_b", hmaster, 3);
        tick;
        check("fp_c", fp_hgrant, 4'b0010);
        check("rr_c", hmaster, 1);
        hreq = 4'b1000;
        tick;
        check("fp_starve_end", fp_hgrant, 4'b1000);
        check("fp_master", fp_hmaster, 3);

        hreq = 4'b0100;
        hseq = 4'b0100;
        tick;
        tick;
        check("pre_rst_grant", hgrant, 4'b0100);
        #2;
        hreset = 1'b1;
        #1;
        check("mid_rst_grant", hgrant, 0);
        check("mid_rst_master", hmaster, 0);
        check("mid_rst_sel", hsel_dp, 0);
        check("mid_rst_dp", hmaster_dp, 0);
        check("mid_rst_lock", hlocked, 0);
        #3;
        hreset = 1'b0;
        hreq = 4'b0110;
        hseq = 4'b0000;
        tick;
        check("post_rst_grant", hgrant, 4'b0010);
        check("post_rst_master", hmaster, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave-port arbiter for the AHB bus matrix: one instance sits in front of each slave port and decides which of the MAS_NUM masters drives that slave's address phase. It holds ownership across bursts and locked sequences, re-arbitrates only on HREADY-high edges, and tracks the data-phase owner so the matrix can route HRDATA/HRESP/HREADYOUT back to the correct master.

## Interface
- MAS_NUM, 4, number of master ports competing for this slave
- MAS_W, $clog2(MAS_NUM), width of master index
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)

- hclk  in  1  bus clock, all state on rising edge
- hreset  in  1  asynchronous, active-high reset
- hreq  in  MAS_NUM  master m addresses this slave with HTRANS NONSEQ/SEQ (decoded HSEL & HTRANS[1])
- hseq  in  MAS_NUM  master m's HTRANS == SEQ (burst continuation)
- hlock  in  MAS_NUM  master m's HMASTLOCK
- hready  in  1  HREADY of this slave port
- hgrant  out  MAS_NUM  one-hot address-phase grant, all-zero when unowned
- hmaster  out  MAS_W  index of address-phase owner
- hmaster_dp  out  MAS_W  index of master in data phase
- hsel_dp  out  1  a real transfer is in data phase to this slave
- hlocked  out  1  current ownership is held by HMASTLOCK

## Operation
- States: IDLE (no owner), OWN (owner granted, not locked), LOCK (owner held by hlock).
- All state/output updates only on hclk edges with hready=1; hready=0 freezes everything.
- Hold condition for owner o: hlock[o] | (hseq[o] & hreq[o]).
- On hready edge:
  - owner valid and hold true -> keep owner; state LOCK if hlock[o] else OWN.
  - else if |hreq -> grant winner; state OWN (LOCK if hlock[winner]).
  - else -> IDLE, hgrant=0, hmaster retains last value.
- Winner, PRIO_MODE=0: first asserted hreq searching from (rr_ptr+1) mod MAS_NUM upward with wrap; rr_ptr <= winner on each new grant. Current owner without hold competes like any other master (not favoured).
- Winner, PRIO_MODE=1: lowest asserted index.
- Data phase: on each hready edge, hmaster_dp <= hmaster, hsel_dp <= (state!=IDLE) & hreq[hmaster].
- LOCK persists while hlock[o] even with hreq[o]=0 (locked idle cycles); no other master granted.
- hgrant is always one-hot or zero; hgrant[hmaster] set iff state != IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, hgrant=0, hmaster=0, hmaster_dp=0, hsel_dp=0, hlocked=0, rr_ptr=MAS_NUM-1 (master 0 wins first).
- Grant latency: hreq sampled at hready edge N -> hgrant valid after edge N; master's address phase accepted at next hready edge N+k; hsel_dp/hmaster_dp valid after that edge.
- Handover: last beat of burst (hseq low) at hready edge -> new owner granted same edge; zero dead cycles between back-to-back masters.
- Wait states: hready=0 for any number of cycles holds grant, owner, data-phase outputs unchanged.
- Reset mid-burst: immediate drop to reset values; no burst resumption.
- Simultaneous hlock assert by new winner: LOCK entered on the grant edge.

## Structure
- Package ahb_arb_pkg: state enum (IDLE/OWN/LOCK), PRIO_RR/PRIO_FIXED constants, shared with matrix top.
- Sub-module ahb_rr_picker: combinational rotate-and-priority-encode, inputs req vector + start pointer, outputs one-hot and index; fixed mode uses start pointer MAS_NUM-1.
- Arbiter top holds state register, rr_ptr, hgrant/hmaster, data-phase registers.

## Test plan
- Reset then hreq=4'b1111, hready=1, RR -> grants 0,1,2,3,0 on consecutive edges with hseq=0; hmaster_dp lags hmaster one edge.
- Master 1 4-beat INCR4 (hseq=1 beats 2-4) while master 2 requests -> hgrant=0010 four edges, then 0100 on edge after last beat, no gap.
- hready=0 for 3 cycles mid-burst -> hgrant, hmaster, hmaster_dp, hsel_dp frozen; resume on hready=1.
- Master 3 hlock=1 with hreq toggling 1,0,1, master 0 requesting -> hlocked=1, hgrant=1000 throughout; master 0 granted edge after hlock drops.
- PRIO_MODE=1, hreq=4'b1010 -> master 1 granted repeatedly, master 3 starves until hreq[1]=0.
- Assert hreset mid-burst -> outputs at reset values same cycle, first post-reset grant to lowest requester from index 0.
